// File: rtl/fpu_issue_ctrl_if.sv
// Request/response/FPU-side bundle for fpu_issue_ctrl; slave is the controller view.
// Requests are valid/ready, the fpu_* side is non-stallable, responses are valid/ready.
interface fpu_issue_ctrl_if #(
  parameter int TAG_W = 4
);
  logic             req_valid;
  logic             req_ready;
  logic [31:0]      req_a;
  logic [31:0]      req_b;
  logic [1:0]       req_op;
  logic [TAG_W-1:0] req_tag;

  logic [31:0]      fpu_a;
  logic [31:0]      fpu_b;
  logic [1:0]       fpu_op;
  logic [31:0]      fpu_out;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_data;
  logic [TAG_W-1:0] rsp_tag;
  logic [1:0]       rsp_op;

  modport master (
    output req_valid, req_a, req_b, req_op, req_tag, rsp_ready, fpu_out,
    input  req_ready, fpu_a, fpu_b, fpu_op, rsp_valid, rsp_data, rsp_tag, rsp_op
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, req_tag, rsp_ready, fpu_out,
    output req_ready, fpu_a, fpu_b, fpu_op, rsp_valid, rsp_data, rsp_tag, rsp_op
  );
endinterface

// File: rtl/fpu_issue_ctrl.sv
// Issue/collect wrapper for a non-stallable FPU: result lands in a FWFT FIFO FPU_LATENCY edges after accept.
// Credits (inflight + FIFO count) gate req_ready so the FIFO never overflows; FPU_ISSUE_STATS_EN adds counters.
module fpu_issue_ctrl #(
  parameter int FPU_LATENCY = 5,
  parameter int FIFO_DEPTH  = 8,
  parameter int TAG_W       = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  fpu_issue_ctrl_if.slave               bus,
  output logic [$clog2(FIFO_DEPTH):0]   inflight
`ifdef FPU_ISSUE_STATS_EN
  ,
  output logic [31:0]                   stat_issued,
  output logic [31:0]                   stat_retired,
  output logic [31:0]                   stat_stall
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(FIFO_DEPTH);

  logic [FPU_LATENCY-1:0] r_sr_vld;
  logic [TAG_W-1:0]       r_sr_tag [FPU_LATENCY];
  logic [1:0]             r_sr_op  [FPU_LATENCY];

  logic [31:0]            r_mem_dat [FIFO_DEPTH];
  logic [TAG_W-1:0]       r_mem_tag [FIFO_DEPTH];
  logic [1:0]             r_mem_op  [FIFO_DEPTH];
  logic [PTR_W-1:0]       r_wr_ptr;
  logic [PTR_W-1:0]       r_rd_ptr;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       r_inflight;

  logic                   w_issue;
  logic                   w_push;
  logic                   w_pop;
  logic [CNT_W:0]         w_outstanding;

  assign w_outstanding = {1'b0, r_inflight} + {1'b0, r_cnt};
  assign bus.req_ready = !rst && (w_outstanding < DEPTH_C);
  assign w_issue       = bus.req_valid && bus.req_ready;
  assign w_push        = r_sr_vld[FPU_LATENCY-1];
  assign w_pop         = bus.rsp_valid && bus.rsp_ready;

  // fpu_top samples every cycle; only accepted cycles enter the tracking pipe.
  assign bus.fpu_a  = bus.req_a;
  assign bus.fpu_b  = bus.req_b;
  assign bus.fpu_op = bus.req_op;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sr_vld <= '0;
      for (int k = 0; k < FPU_LATENCY; k++) begin
        r_sr_tag[k] <= '0;
        r_sr_op[k]  <= '0;
      end
    end else begin
      r_sr_vld[0] <= w_issue;
      r_sr_tag[0] <= bus.req_tag;
      r_sr_op[0]  <= bus.req_op;
      for (int k = 1; k < FPU_LATENCY; k++) begin
        r_sr_vld[k] <= r_sr_vld[k-1];
        r_sr_tag[k] <= r_sr_tag[k-1];
        r_sr_op[k]  <= r_sr_op[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_dat[r_wr_ptr] <= bus.fpu_out;
      r_mem_tag[r_wr_ptr] <= r_sr_tag[FPU_LATENCY-1];
      r_mem_op[r_wr_ptr]  <= r_sr_op[FPU_LATENCY-1];
    end
  end

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_cnt      <= '0;
      r_inflight <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
      case ({w_issue, w_push})
        2'b10:   r_inflight <= r_inflight + 1'b1;
        2'b01:   r_inflight <= r_inflight - 1'b1;
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  assign bus.rsp_valid = (r_cnt != '0);
  assign bus.rsp_data  = r_mem_dat[r_rd_ptr];
  assign bus.rsp_tag   = r_mem_tag[r_rd_ptr];
  assign bus.rsp_op    = r_mem_op[r_rd_ptr];
  assign inflight      = r_inflight;

`ifdef FPU_ISSUE_STATS_EN
  logic [31:0] r_stat_issued;
  logic [31:0] r_stat_retired;
  logic [31:0] r_stat_stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat_issued  <= '0;
      r_stat_retired <= '0;
      r_stat_stall   <= '0;
    end else begin
      if (w_issue && (r_stat_issued != '1))  r_stat_issued  <= r_stat_issued + 1'b1;
      if (w_pop && (r_stat_retired != '1))   r_stat_retired <= r_stat_retired + 1'b1;
      if (bus.req_valid && !bus.req_ready && (r_stat_stall != '1))
        r_stat_stall <= r_stat_stall + 1'b1;
    end
  end

  assign stat_issued  = r_stat_issued;
  assign stat_retired = r_stat_retired;
  assign stat_stall   = r_stat_stall;
`endif

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Bench for fpu_issue_ctrl: a behavioural fpu_top stand-in plus a credit/timing reference model.
// Expected responses are queued at issue and popped by a negedge monitor.
module tb_fpu_issue_ctrl;

  localparam int LAT   = 5;
  localparam int DEPTH = 8;

  typedef struct {
    logic [31:0] dat;
    logic [3:0]  tag;
    logic [1:0]  op;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  inflight;
  logic [31:0] stat_issued;
  logic [31:0] stat_retired;
  logic [31:0] stat_stall;
  logic [31:0] fpu_pipe [LAT];

  int   n_cmp  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  bit   rnd    = 1'b0;
  exp_t sb [$];
  int   acc_edge [$];
  int   n_cap, n_pop, e_fill, e_infl;
  logic [31:0] m_issued, m_retired, m_stall;

  fpu_issue_ctrl_if #(.TAG_W(4)) bus ();

  fpu_issue_ctrl #(.FPU_LATENCY(LAT), .FIFO_DEPTH(DEPTH), .TAG_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus.slave),
    .inflight     (inflight)
`ifdef FPU_ISSUE_STATS_EN
    ,
    .stat_issued  (stat_issued),
    .stat_retired (stat_retired),
    .stat_stall   (stat_stall)
`endif
  );

`ifndef FPU_ISSUE_STATS_EN
  assign stat_issued  = '0;
  assign stat_retired = '0;
  assign stat_stall   = '0;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] s2d(input logic [31:0] f);
    return {f[31], 11'({3'b000, f[30:23]} + 11'd896), f[22:0], 29'd0};
  endfunction

  function automatic logic [31:0] d2s(input real r);
    logic [63:0] d;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return 32'd0;
    return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
  endfunction

  // Arithmetic stand-in for fpu_top: 0 add, 1 sub, 2 mul, 3 bitwise xor.
  function automatic logic [31:0] fpu_func(input logic [31:0] a, input logic [31:0] b,
                                           input logic [1:0] op);
    real ra, rb;
    ra = $bitstoreal(s2d(a));
    rb = $bitstoreal(s2d(b));
    case (op)
      2'd0:    return d2s(ra + rb);
      2'd1:    return d2s(ra - rb);
      2'd2:    return d2s(ra * rb);
      default: return a ^ b;
    endcase
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [7:0] e;
    e = 8'(120 + $urandom_range(0, 15));
    return {1'($urandom_range(0, 1)), e, 23'($urandom)};
  endfunction

  always @(posedge clk) begin
    fpu_pipe[0] <= fpu_func(bus.fpu_a, bus.fpu_b, bus.fpu_op);
    for (int k = 1; k < LAT; k++) fpu_pipe[k] <= fpu_pipe[k-1];
  end
  assign bus.fpu_out = fpu_pipe[LAT-1];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Called just after a rising edge; holds the request for up to max_wait cycles.
  task automatic send(input logic [3:0] tag, input logic [31:0] a, input logic [31:0] b,
                      input logic [1:0] op, input int max_wait, output bit ok);
    ok = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_tag   = tag;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_op    = op;
    for (int i = 0; i < max_wait && !ok; i++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        ok = 1'b1;
        sb.push_back('{fpu_func(a, b, op), tag, op});
      end
      @(posedge clk);
      #1;
      if (rnd) bus.rsp_ready = 1'($urandom_range(0, 1));
    end
    bus.req_valid = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Reference model: issue edge N is inflight through edge N+LAT-1, in the FIFO from N+LAT until popped.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
      chk("rst_inflight", 32'(inflight), 32'd0);
      acc_edge.delete();
      sb.delete();
      n_cap = 0; n_pop = 0;
      m_issued = '0; m_retired = '0; m_stall = '0;
    end else begin
      while (acc_edge.size() > 0 && acc_edge[0] + LAT <= cyc) begin
        void'(acc_edge.pop_front());
        n_cap++;
      end
      e_fill = n_cap - n_pop;
      e_infl = acc_edge.size();
      chk("inflight", 32'(inflight), 32'(e_infl));
      chk("rsp_valid", 32'(bus.rsp_valid), 32'(e_fill > 0));
      chk("req_ready", 32'(bus.req_ready), 32'((e_infl + e_fill) < DEPTH));
`ifdef FPU_ISSUE_STATS_EN
      chk("stat_issued", stat_issued, m_issued);
      chk("stat_retired", stat_retired, m_retired);
      chk("stat_stall", stat_stall, m_stall);
`endif
      if (bus.req_valid && bus.req_ready) begin
        acc_edge.push_back(cyc + 1);
        if (m_issued != '1) m_issued++;
      end
      if (bus.req_valid && !bus.req_ready && m_stall != '1) m_stall++;
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL rsp_unexpected: got tag %h expected no response", bus.rsp_tag);
        end else begin
          e = sb.pop_front();
          chk("rsp_data", bus.rsp_data, e.dat);
          chk("rsp_tag", 32'(bus.rsp_tag), 32'(e.tag));
          chk("rsp_op", 32'(bus.rsp_op), 32'(e.op));
        end
        n_pop++;
        if (m_retired != '1) m_retired++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    bit ok;
    int w;
    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_a = '0; bus.req_b = '0; bus.req_op = '0; bus.req_tag = '0;
    bus.rsp_ready = 1'b0;
    do_reset(3);

    // Single op: 1.0 + 2.0, tag 3.
    send(4'd3, 32'h3F80_0000, 32'h4000_0000, 2'b00, 4, ok);
    chk("single_acc", 32'(ok), 32'd1);
    w = 0;
    for (int i = 1; i <= 10 && w == 0; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) w = i;
    end
    chk("single_latency", 32'(w), 32'd6);
    chk("single_data", bus.rsp_data, 32'h4040_0000);
    chk("single_tag", 32'(bus.rsp_tag), 32'd3);
    chk("single_inflight", 32'(inflight), 32'd0);
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;

    // Fill with no consumer: only DEPTH requests fit.
    do_reset(2);
    for (int t = 0; t < 10; t++) begin
      send(4'(t), rand_fp(), rand_fp(), 2'($urandom_range(0, 3)), 2, ok);
      chk("fill_acc", 32'(ok), 32'(t < DEPTH));
    end
`ifdef FPU_ISSUE_STATS_EN
    chk("fill_stat_issued", stat_issued, 32'd8);
    chk("fill_stat_stall", stat_stall, 32'd4);
`endif
    bus.rsp_ready = 1'b1;
    repeat (14) @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
`ifdef FPU_ISSUE_STATS_EN
    chk("fill_stat_retired", stat_retired, 32'd8);
`endif
    chk("fill_drained", 32'(sb.size()), 32'd0);

    // Credit release: refill, free exactly one slot.
    for (int t = 0; t < DEPTH; t++) begin
      send(4'(t), rand_fp(), rand_fp(), 2'($urandom_range(0, 3)), 4, ok);
      chk("refill_acc", 32'(ok), 32'd1);
    end
    repeat (8) @(posedge clk);
    #1;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    send(4'd8, rand_fp(), rand_fp(), 2'd1, 3, ok);
    chk("credit_acc_tag8", 32'(ok), 32'd1);
    send(4'd9, rand_fp(), rand_fp(), 2'd2, 3, ok);
    chk("credit_block_tag9", 32'(ok), 32'd0);
    bus.rsp_ready = 1'b1;
    repeat (16) @(posedge clk);
    #1;

    // Streaming with continuous pop: push and pop share edges, pointers wrap.
    for (int i = 0; i < 20; i++) begin
      send(4'(i), rand_fp(), rand_fp(), 2'($urandom_range(0, 3)), 4, ok);
      chk("stream_acc", 32'(ok), 32'd1);
    end
    repeat (10) @(posedge clk);
    #1;

    // Reset with operations still in the FPU pipe.
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(4'(10 + i), rand_fp(), rand_fp(), 2'd0, 4, ok);
    repeat (2) @(posedge clk);
    #1;
    do_reset(2);
    @(negedge clk);
    chk("post_rst_req_ready", 32'(bus.req_ready), 32'd1);
    repeat (10) @(posedge clk);
    #1;

    // Randomised traffic with a randomly stalling consumer.
    rnd = 1'b1;
    for (int i = 0; i < 150; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
        bus.rsp_ready = 1'($urandom_range(0, 1));
      end
      send(4'($urandom_range(0, 15)), rand_fp(), rand_fp(), 2'($urandom_range(0, 3)), 20, ok);
    end
    rnd = 1'b0;
    bus.rsp_ready = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    chk("final_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fpu_issue_ctrl.md
Name: fpu_issue_ctrl

Overview:
- Initiator/collector placed in front of fpu_top.
- Accepts tagged operation requests over a valid/ready interface and drives the non-stallable 5-stage FPU pipeline.
- Tracks in-flight operations with a valid/tag shift register, captures each result into a response FIFO, and returns it over valid/ready with its tag.
- Credit logic makes FIFO overflow impossible, even though fpu_top cannot stall.

Parameters:
- FPU_LATENCY, 5, clock edges from operands sampled by fpu_top to result valid on fpu_out.
- FIFO_DEPTH, 8, response FIFO entries; power of 2, must be >= FPU_LATENCY.
- TAG_W, 4, width of request/response tag.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready at a rising edge.
- req_a  in  32  operand A, IEEE-754 single.
- req_b  in  32  operand B, IEEE-754 single.
- req_op  in  2  FPU operator code; passed through, never interpreted.
- req_tag  in  TAG_W  caller tag.
- fpu_a  out  32  to fpu_top a.
- fpu_b  out  32  to fpu_top b.
- fpu_op  out  2  to fpu_top op.
- fpu_out  in  32  from fpu_top out.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready at a rising edge.
- rsp_data  out  32  result.
- rsp_tag  out  TAG_W  tag of the result.
- rsp_op  out  2  op of the result.
- inflight  out  $clog2(FIFO_DEPTH)+1  operations issued but not yet written to the FIFO.

Behaviour:
- Reset (async, active-high) clears:
  - valid shift register and tag/op sideband;
  - FIFO read/write pointers and count;
  - inflight.
- Values during and after reset: rsp_valid=0, inflight=0, req_ready=0 while rst=1.
- fpu_a/fpu_b/fpu_op: combinational copies of req_a/req_b/req_op every cycle. fpu_top samples them regardless; only accepted cycles are tracked.
- Issue at edge N (accept): shift-register stage 0 loads {1, req_tag, req_op}. Otherwise stage 0 loads valid=0. Stage k moves to k+1 every edge.
- Capture: when stage FPU_LATENCY-1 is valid, edge N+FPU_LATENCY writes {fpu_out, tag, op} into the FIFO. With defaults, the result is written at edge N+5 and rsp_valid is visible after edge N+5.
- Credits: outstanding = inflight + fifo_count. req_ready = !rst && (outstanding < FIFO_DEPTH). Counts are registers, so there is no combinational path from rsp_ready or req_valid to req_ready.
- Order: the pipeline is in-order, so responses are in issue order.
- FIFO is first-word-fall-through: rsp_data/tag/op show the head whenever rsp_valid=1 and hold stable until popped.
- Simultaneous push and pop: count unchanged; allowed at any fill level including full. Pointers wrap modulo FIFO_DEPTH.
- Accounting on the same edge:
  - issue and capture: inflight unchanged;
  - pop: frees one credit, seen by req_ready in the following cycle.
- Empty FIFO with rsp_ready=1: no pop, no state change.
- Full (outstanding==FIFO_DEPTH): req_ready=0; req_valid is ignored.
- Reset mid-flight: tracked operations are discarded. Results still draining from fpu_top are never written, because the valid bits are already cleared.

Optional Feature:
- Macro: FPU_ISSUE_STATS_EN.
- When defined, adds these 32-bit output ports:
  - stat_issued: increments on each accept.
  - stat_retired: increments on each pop.
  - stat_stall: increments each cycle with req_valid && !req_ready.
- All three reset to 0 and saturate at 0xFFFFFFFF.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Single op, with fpu_top attached: after reset, accept a=0x3F800000, b=0x40000000, op=2'b00 (add), tag=3 at edge N. Require rsp_valid=0 through edge N+4, then rsp_valid=1 after edge N+5 with rsp_data=0x40400000, rsp_tag=3, inflight back to 0.
- Fill, with rsp_ready=0: present 10 back-to-back requests, tags 0..9. Require exactly 8 accepted (tags 0..7) and req_ready=0 after the 8th accept. Then with rsp_ready=1, require responses tags 0..7 in order.
- Credit release: from full, pulse rsp_ready for one cycle. Require req_ready=1 in the next cycle only, exactly one more accept (tag 8), and req_ready=0 again once it is outstanding.
- Simultaneous push/pop: with FIFO count=1 and continuous issue plus rsp_ready=1, require count constant and tag order preserved across pointer wrap (20 ops).
- Reset mid-flight: issue 3 ops, assert rst for 2 cycles two edges later. Require rsp_valid=0 for the next 10 cycles, inflight=0, and req_ready=1 on the first cycle after rst falls.
- With FPU_ISSUE_STATS_EN: run the fill scenario. Require stat_issued=8, stat_stall=2 cycles per blocked request held, and stat_retired=8 after draining.
